// File: rtl/env_pkg.sv
// Shared constants and helpers for the envelope decimator.
// Holds the reduction mode encodings and the saturating rectifier.
package env_pkg;

    localparam logic MODE_MEAN = 1'b0;
    localparam logic MODE_PEAK = 1'b1;

    // |x| of a w-bit signed value (sign-extended to 32 bits);
    // the most negative value clips to the largest positive one.
    function automatic logic [31:0] sat_abs(
        input logic signed [31:0] x,
        input int                 w
    );
        logic signed [31:0] lim;
        logic signed [31:0] mag;
        lim = (32'sd1 <<< (w - 1)) - 32'sd1;
        mag = (x < 0) ? -x : x;
        if (mag > lim) begin
            mag = lim;
        end
        return mag;
    endfunction

endpackage

// File: rtl/env_out_reg.sv
// Single-entry AXI-Stream output register for envelope values.
// ready_out tells the producer a load this cycle will not be lost.
module env_out_reg #(
    parameter int DATA_W = 16,
    parameter int CH_W   = 1
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic              load,
    input  logic [DATA_W-1:0] data,
    input  logic [CH_W-1:0]   user,
    input  logic              last,
    output logic              ready_out,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic [CH_W-1:0]   m_axis_tuser,
    output logic              m_axis_tlast,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready
);

    assign ready_out = !m_axis_tvalid | m_axis_tready;

    // Reload on a new value, otherwise empty once the sink accepts.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            m_axis_tdata  <= '0;
            m_axis_tuser  <= '0;
            m_axis_tlast  <= 1'b0;
            m_axis_tvalid <= 1'b0;
        end else if (load) begin
            m_axis_tdata  <= data;
            m_axis_tuser  <= user;
            m_axis_tlast  <= last;
            m_axis_tvalid <= 1'b1;
        end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
        end
    end

endmodule

// File: rtl/envelope_decimator.sv
// Rectify a TDM stream and reduce DECIM samples per channel to one
// envelope value, by boxcar mean or peak, chosen per window.
module envelope_decimator
    import env_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int NUM_CH   = 2,
    parameter int DECIM    = 8,
    parameter int LOG2_DEC = 3,
    parameter int CH_W     = 1
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic              cfg_mode,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic              s_axis_tvalid,
    input  logic              s_axis_tlast,
    output logic              s_axis_tready,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic [CH_W-1:0]   m_axis_tuser,
    output logic              m_axis_tlast,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              err_tlast
);

    localparam int ACC_W = DATA_W + LOG2_DEC;

    if ((1 << LOG2_DEC) != DECIM) begin : g_bad_decim
        $error("LOG2_DEC does not match DECIM");
    end
    if (NUM_CH < 1) begin : g_bad_ch
        $error("NUM_CH must be at least 1");
    end

    logic [LOG2_DEC-1:0] cnt;
    logic [CH_W-1:0]     ch;
    logic [ACC_W-1:0]    acc [NUM_CH];
    logic                mode_q;
    logic                en_q;

    logic                fire;
    logic                last_ch;
    logic                win_end;
    logic                win_start;
    logic                mode_cur;
    logic [DATA_W-1:0]   rect;
    logic [ACC_W-1:0]    rect_ext;
    logic [ACC_W-1:0]    acc_cur;
    logic [ACC_W-1:0]    acc_next;
    logic [DATA_W-1:0]   out_d;
    logic                out_rdy;
    logic                load;

    assign last_ch   = (ch == CH_W'(NUM_CH - 1));
    assign win_end   = &cnt;
    assign win_start = (cnt == '0);
    assign fire      = s_axis_tvalid & s_axis_tready;
    assign load      = fire & win_end;

    // Only a window-closing sample can be blocked, and only by a full output.
    assign s_axis_tready = en_q & (!win_end | out_rdy);

    // The first sample of channel 0 picks the mode for the whole window.
    assign mode_cur = (win_start && ch == '0) ? cfg_mode : mode_q;

    assign rect     = DATA_W'(sat_abs(32'(signed'(s_axis_tdata)), DATA_W));
    assign rect_ext = {{LOG2_DEC{1'b0}}, rect};
    assign acc_cur  = acc[ch];

    // Next accumulator value: load on window start, else sum or max.
    always_comb begin
        acc_next = rect_ext;
        if (!win_start) begin
            if (mode_cur == MODE_PEAK) begin
                acc_next = (acc_cur > rect_ext) ? acc_cur : rect_ext;
            end else begin
                acc_next = acc_cur + rect_ext;
            end
        end
    end

    assign out_d = (mode_cur == MODE_PEAK) ? acc_next[DATA_W-1:0]
                                           : acc_next[ACC_W-1:LOG2_DEC];

    // Input ready comes up one cycle after reset is released.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            en_q <= 1'b0;
        end else begin
            en_q <= 1'b1;
        end
    end

    // Channel/sample counters, mode latch and tlast consistency flag.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            cnt       <= '0;
            ch        <= '0;
            mode_q    <= MODE_MEAN;
            err_tlast <= 1'b0;
        end else if (fire) begin
            if (win_start && ch == '0) begin
                mode_q <= cfg_mode;
            end
            if (s_axis_tlast != last_ch) begin
                err_tlast <= 1'b1;
            end
            if (last_ch || s_axis_tlast) begin
                ch <= '0;
            end else begin
                ch <= ch + CH_W'(1);
            end
            if (last_ch && s_axis_tlast) begin
                cnt <= cnt + LOG2_DEC'(1);
            end
        end
    end

    // Per-channel accumulators, updated only for the active channel.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                acc[i] <= '0;
            end
        end else if (fire) begin
            acc[ch] <= acc_next;
        end
    end

    env_out_reg #(
        .DATA_W (DATA_W),
        .CH_W   (CH_W)
    ) u_out (
        .aclk          (aclk),
        .areset        (areset),
        .load          (load),
        .data          (out_d),
        .user          (ch),
        .last          (last_ch),
        .ready_out     (out_rdy),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready)
    );

endmodule

// File: tb/tb_envelope_decimator.sv
// Directed and randomized bench for envelope_decimator (2 ch, DECIM 8).
// Expected values come from a window-level model of the envelope rules.
module tb_envelope_decimator;

    localparam int DW  = 16;
    localparam int DEC = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cfg_mode = 1'b0;
    logic [DW-1:0] s_data = '0;
    logic          s_valid = 1'b0;
    logic          s_last = 1'b0;
    logic          s_ready;
    logic [DW-1:0] m_data;
    logic [0:0]    m_user;
    logic          m_last;
    logic          m_valid;
    logic          m_ready = 1'b1;
    logic          err;

    int n_assert = 0;
    int n_fail   = 0;

    int exp_d[$];
    int exp_u[$];
    int exp_l[$];
    int win0[$];
    int win1[$];
    int frame    = 0;
    bit win_mode = 1'b0;
    bit rand_rdy = 1'b0;
    bit hold_v   = 1'b0;
    int hold_d   = 0;

    always #5 clk = ~clk;

    envelope_decimator #(
        .DATA_W   (DW),
        .NUM_CH   (2),
        .DECIM    (DEC),
        .LOG2_DEC (3),
        .CH_W     (1)
    ) dut (
        .aclk          (clk),
        .areset        (rst),
        .cfg_mode      (cfg_mode),
        .s_axis_tdata  (s_data),
        .s_axis_tvalid (s_valid),
        .s_axis_tlast  (s_last),
        .s_axis_tready (s_ready),
        .m_axis_tdata  (m_data),
        .m_axis_tuser  (m_user),
        .m_axis_tlast  (m_last),
        .m_axis_tvalid (m_valid),
        .m_axis_tready (m_ready),
        .err_tlast     (err)
    );

    task automatic chk(input string tag, input int obs, input int expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    function automatic int rabs(input int x);
        if (x == -32768) return 32767;
        return (x < 0) ? -x : x;
    endfunction

    function automatic int reduce(input int q[$], input bit pk);
        int r;
        r = 0;
        foreach (q[i]) begin
            if (pk) r = (q[i] > r) ? q[i] : r;
            else    r = r + q[i];
        end
        return pk ? r : r / DEC;
    endfunction

    // Model: record one sample; at the last frame, queue the window result.
    task automatic model_add(input int c, input int x);
        if (c == 0 && frame == 0) win_mode = cfg_mode;
        if (c == 0) win0.push_back(rabs(x));
        else        win1.push_back(rabs(x));
        if (frame == DEC - 1) begin
            exp_d.push_back(reduce(c == 0 ? win0 : win1, win_mode));
            exp_u.push_back(c);
            exp_l.push_back(c == 1 ? 1 : 0);
            if (c == 0) win0.delete();
            else        win1.delete();
        end
        if (c == 1) frame = (frame + 1) % DEC;
    endtask

    // Entered just after a rising edge; returns just after the transfer edge.
    task automatic send(input int x, input bit l);
        bit ok;
        ok = 1'b0;
        s_data  = DW'(x);
        s_last  = l;
        s_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (rand_rdy) m_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (s_ready) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (!ok) chk("send_timeout", 0, 1);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic send_frame(input int x0, input int x1);
        model_add(0, x0);
        send(x0, 1'b0);
        model_add(1, x1);
        send(x1, 1'b1);
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (exp_d.size() != 0 && k < 300) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("drain_left", exp_d.size(), 0);
    endtask

    // Output monitor: check each accepted beat and hold-stability.
    always @(negedge clk) begin
        if (rst) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v && m_valid) chk("hold_stable", int'(m_data), hold_d);
            hold_v = m_valid && !m_ready;
            hold_d = int'(m_data);
            if (m_valid && m_ready) begin
                if (exp_d.size() == 0) begin
                    chk("unexpected_out", int'(m_data), -1);
                end else begin
                    chk("out_data", int'(m_data), exp_d.pop_front());
                    chk("out_user", int'(m_user), exp_u.pop_front());
                    chk("out_last", int'(m_last), exp_l.pop_front());
                end
            end
        end
    end

    initial begin
        int a[8];
        int x0;
        int x1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_sready", int'(s_ready), 0);
        chk("rst_mvalid", int'(m_valid), 0);
        chk("rst_mdata", int'(m_data), 0);
        chk("rst_err", int'(err), 0);
        rst = 1'b0;
        chk("rel_sready0", int'(s_ready), 0);
        @(posedge clk);
        #1;
        chk("rel_sready1", int'(s_ready), 1);

        // Mean of a known window -> 35 on ch0
        a = '{0, 10, -20, 30, -40, 50, -60, 70};
        cfg_mode = 1'b0;
        for (int f = 0; f < DEC; f++) send_frame(a[f], 3);
        drain();

        // Peak with the most negative sample saturating
        cfg_mode = 1'b1;
        a = '{5, -32768, 100, 7, -9, 0, 12, 1};
        for (int f = 0; f < DEC; f++) send_frame(a[f], -f * 100);
        drain();

        // Constant channels: 100 and -4
        cfg_mode = 1'b0;
        for (int f = 0; f < DEC; f++) send_frame(100, -4);
        drain();

        // Backpressure: second completing sample must stall
        m_ready = 1'b0;
        for (int f = 0; f < DEC - 1; f++) send_frame(f * 3, -f * 5);
        model_add(0, 999);
        send(999, 1'b0);
        chk("bp_mvalid", int'(m_valid), 1);
        model_add(1, -1234);
        s_data  = DW'(-1234);
        s_last  = 1'b1;
        s_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("bp_sready", int'(s_ready), 0);
            @(posedge clk);
            #1;
        end
        m_ready = 1'b1;
        @(negedge clk);
        chk("bp_release", int'(s_ready), 1);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        chk("bp_reload", int'(m_valid), 1);
        drain();

        // Mode change mid-window applies to the next window
        cfg_mode = 1'b0;
        for (int f = 0; f < 3; f++) send_frame(800 - f * 100, 40);
        cfg_mode = 1'b1;
        for (int f = 3; f < DEC; f++) send_frame(8, -40 + f);
        for (int f = 0; f < 3; f++) send_frame(20 * f, 7);
        cfg_mode = 1'b0;
        for (int f = 3; f < DEC; f++) send_frame(-f, 300 * f);
        drain();

        // Randomized windows, modes and sink readiness
        rand_rdy = 1'b1;
        for (int w = 0; w < 6; w++) begin
            for (int f = 0; f < DEC; f++) begin
                if ($urandom_range(0, 5) == 0) cfg_mode = ~cfg_mode;
                x0 = int'($urandom_range(0, 65535)) - 32768;
                x1 = ($urandom_range(0, 9) == 0) ? -32768
                   : int'($urandom_range(0, 65535)) - 32768;
                send_frame(x0, x1);
            end
        end
        rand_rdy = 1'b0;
        m_ready  = 1'b1;
        drain();

        // Early tlast on ch0: sticky error, channel returns to 0
        chk("err_before", int'(err), 0);
        send(1234, 1'b1);
        chk("err_set", int'(err), 1);
        for (int f = 0; f < DEC; f++) send_frame(f * 11, -f * 13);
        drain();
        chk("err_sticky", int'(err), 1);

        // Reset with a pending output and a partial window
        m_ready = 1'b0;
        for (int f = 0; f < DEC - 1; f++) send_frame(50, 60);
        model_add(0, 70);
        send(70, 1'b0);
        chk("pre_rst_mvalid", int'(m_valid), 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_mvalid", int'(m_valid), 0);
        chk("mid_rst_mdata", int'(m_data), 0);
        chk("mid_rst_err", int'(err), 0);
        chk("mid_rst_sready", int'(s_ready), 0);
        exp_d.delete();
        exp_u.delete();
        exp_l.delete();
        win0.delete();
        win1.delete();
        frame = 0;
        @(posedge clk);
        #1;
        rst     = 1'b0;
        m_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("post_rst_mvalid", int'(m_valid), 0);
        cfg_mode = 1'b1;
        for (int f = 0; f < DEC; f++) send_frame(-f * 7, f * 9);
        drain();
        chk("post_rst_err", int'(err), 0);

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
